// File: rtl/spwm_pkg.sv
// ============================================================================
// Module  : spwm_pkg
// Brief   : Shared encodings and defaults for the SPWM dead-time gate driver.
// Revision: 1.0
// ============================================================================
`default_nettype none

package spwm_pkg;

  typedef enum logic [1:0] {
    PH_OFF = 2'd0,
    PH_DT  = 2'd1,
    PH_HI  = 2'd2,
    PH_LO  = 2'd3
  } phase_state_e;

  typedef enum logic [1:0] {
    REQ_NONE    = 2'd0,
    REQ_H       = 2'd1,
    REQ_L       = 2'd2,
    REQ_ILLEGAL = 2'd3
  } req_e;

  localparam int DEAD_CYCLES_DEF = 20;
  localparam int CNT_W_DEF       = 8;

  function automatic req_e decode_req(input logic h, input logic l);
    case ({h, l})
      2'b10:   return REQ_H;
      2'b01:   return REQ_L;
      2'b11:   return REQ_ILLEGAL;
      default: return REQ_NONE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/deadtime_phase.sv
// ============================================================================
// Module  : deadtime_phase
// Brief   : One half-bridge: input register, request decode, dead-time FSM.
// Revision: 1.0
// ============================================================================
`default_nettype none

module deadtime_phase
  import spwm_pkg::*;
#(
  parameter int DEAD_CYCLES = DEAD_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic kill_i,
  input  logic clr_i,
  input  logic ph_i,
  input  logic pl_i,
  output logic gh_o,
  output logic gl_o,
  output logic err_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEAD_CYCLES - 1);

  logic         ph_q, pl_q;
  logic         err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  phase_state_e state_q, state_d;
  req_e         req;

  assign req = decode_req(ph_q, pl_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ph_q    <= 1'b0;
      pl_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      state_q <= PH_OFF;
    end else begin
      ph_q    <= ph_i;
      pl_q    <= pl_i;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = (clr_i ? 1'b0 : err_q) | (req == REQ_ILLEGAL);
    if (kill_i) begin
      state_d = PH_OFF;
      cnt_d   = '0;
    end else begin
      case (state_q)
        PH_OFF: begin
          if (req == REQ_H || req == REQ_L) begin
            state_d = PH_DT;
            cnt_d   = '0;
          end
        end
        PH_DT: begin
          // Target side is whatever is requested in the last dead-time cycle.
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            case (req)
              REQ_H:   state_d = PH_HI;
              REQ_L:   state_d = PH_LO;
              default: state_d = PH_OFF;
            endcase
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PH_HI: begin
          if (req != REQ_H) begin
            state_d = PH_DT;
            cnt_d   = '0;
          end
        end
        PH_LO: begin
          if (req != REQ_L) begin
            state_d = PH_DT;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = PH_OFF;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign gh_o  = (state_q == PH_HI);
  assign gl_o  = (state_q == PH_LO);
  assign err_o = err_q;

endmodule

`default_nettype wire

// File: rtl/deadtime_gate_driver.sv
// ============================================================================
// Module  : deadtime_gate_driver
// Brief   : Three-phase gate driver with dead time, fault latch and ERR flags.
// Revision: 1.0
// ============================================================================
`default_nettype none

module deadtime_gate_driver
  import spwm_pkg::*;
#(
  parameter int DEAD_CYCLES = DEAD_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       flt_i,
  input  logic       clr_i,
  input  logic       pha_i,
  input  logic       pla_i,
  input  logic       phb_i,
  input  logic       plb_i,
  input  logic       phc_i,
  input  logic       plc_i,
  output logic       gha_o,
  output logic       gla_o,
  output logic       ghb_o,
  output logic       glb_o,
  output logic       ghc_o,
  output logic       glc_o,
  output logic       fault_o,
  output logic [2:0] err_o
);

  logic       flt_s1_q, flt_s2_q;
  logic       fault_q, fault_d;
  logic       clr_ok, kill;
  logic [2:0] ph, pl, gh, gl;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flt_s1_q <= 1'b0;
      flt_s2_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      flt_s1_q <= flt_i;
      flt_s2_q <= flt_s1_q;
      fault_q  <= fault_d;
    end
  end

  // A clear is only honoured once the synchronised fault has gone away.
  assign clr_ok  = clr_i & ~flt_s2_q;
  assign fault_d = flt_s2_q | (fault_q & ~clr_ok);
  assign kill    = ~en_i | fault_q | flt_s2_q;

  assign ph = {phc_i, phb_i, pha_i};
  assign pl = {plc_i, plb_i, pla_i};

  for (genvar i = 0; i < 3; i++) begin : g_phase
    deadtime_phase #(
      .DEAD_CYCLES(DEAD_CYCLES),
      .CNT_W      (CNT_W)
    ) u_phase (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .kill_i(kill),
      .clr_i (clr_ok),
      .ph_i  (ph[i]),
      .pl_i  (pl[i]),
      .gh_o  (gh[i]),
      .gl_o  (gl[i]),
      .err_o (err_o[i])
    );
  end

  assign {ghc_o, ghb_o, gha_o} = gh;
  assign {glc_o, glb_o, gla_o} = gl;
  assign fault_o = fault_q;

endmodule

`default_nettype wire

// File: tb/tb_deadtime_gate_driver.sv
// Directed bench for deadtime_gate_driver with DEAD_CYCLES=4.
`timescale 1ns/1ps
`default_nettype none

module tb_deadtime_gate_driver;

  logic clk, rst_n, en, flt, clr;
  logic pha, pla, phb, plb, phc, plc;
  logic gha, gla, ghb, glb, ghc, glc, fault;
  logic [2:0] err;

  int total = 0;
  int bad   = 0;

  deadtime_gate_driver #(.DEAD_CYCLES(4), .CNT_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .flt_i(flt), .clr_i(clr),
    .pha_i(pha), .pla_i(pla), .phb_i(phb), .plb_i(plb), .phc_i(phc), .plc_i(plc),
    .gha_o(gha), .gla_o(gla), .ghb_o(ghb), .glb_o(glb), .ghc_o(ghc), .glc_o(glc),
    .fault_o(fault), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; flt = 1'b0; clr = 1'b0;
    pha = 1'b0; pla = 1'b1; phb = 1'b0; plb = 1'b0; phc = 1'b0; plc = 1'b0;
    tick(3);
    total++;
    if ({gha, gla, ghb, glb, ghc, glc, fault, err} !== 10'b0) begin
      bad++;
      $display("FAIL reset_state: got %b want 0", {gha, gla, ghb, glb, ghc, glc, fault, err});
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick(1);
      total++;
      if (gla !== (e >= 6) || gha !== 1'b0) begin
        bad++;
        $display("FAIL reset_first_on edge%0d: gha=%b gla=%b want gha=0 gla=%b", e, gha, gla, (e >= 6));
      end
    end
  endtask

  task automatic test_handover();
    int zeros;
    zeros = 0;
    pha = 1'b1; pla = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick(1);
      if (!gha && !gla) zeros++;
      total++;
      if (gla !== (e < 2) || gha !== (e >= 6)) begin
        bad++;
        $display("FAIL handover edge%0d: gha=%b gla=%b want gha=%b gla=%b", e, gha, gla, (e >= 6), (e < 2));
      end
    end
    total++;
    if (zeros != 4) begin
      bad++;
      $display("FAIL handover_deadtime: got %0d cycles want 4", zeros);
    end
    pha = 1'b0; pla = 1'b1;
    tick(8);
    total++;
    if (gla !== 1'b1 || gha !== 1'b0) begin
      bad++;
      $display("FAIL handback: gha=%b gla=%b want 0 1", gha, gla);
    end
  endtask

  task automatic test_glitch();
    int zeros;
    zeros = 0;
    pha = 1'b1; pla = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick(1);
      if (e == 2) begin pha = 1'b0; pla = 1'b1; end
      if (!gla) zeros++;
      total++;
      if (gha !== 1'b0 || gla !== (e < 2 || e >= 6)) begin
        bad++;
        $display("FAIL glitch edge%0d: gha=%b gla=%b want gha=0 gla=%b", e, gha, gla, (e < 2 || e >= 6));
      end
    end
    total++;
    if (zeros != 4) begin
      bad++;
      $display("FAIL glitch_deadtime: got %0d cycles want 4", zeros);
    end
  endtask

  task automatic test_illegal();
    phb = 1'b1; plb = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick(1);
      total++;
      if (ghb !== 1'b0 || glb !== 1'b0 || err !== ((e >= 2) ? 3'b010 : 3'b000)) begin
        bad++;
        $display("FAIL illegal edge%0d: ghb=%b glb=%b err=%b want 0 0 %b", e, ghb, glb, err, ((e >= 2) ? 3'b010 : 3'b000));
      end
    end
    phb = 1'b0; plb = 1'b0;
    tick(6);
    total++;
    if (err !== 3'b010 || ghb !== 1'b0 || glb !== 1'b0) begin
      bad++;
      $display("FAIL err_sticky: err=%b ghb=%b glb=%b want 010 0 0", err, ghb, glb);
    end
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    total++;
    if (err !== 3'b000 || fault !== 1'b0) begin
      bad++;
      $display("FAIL err_clear: err=%b fault=%b want 000 0", err, fault);
    end
  endtask

  task automatic test_fault();
    phc = 1'b1; plc = 1'b0;
    tick(8);
    total++;
    if (ghc !== 1'b1 || glc !== 1'b0 || gla !== 1'b1) begin
      bad++;
      $display("FAIL fault_pre: ghc=%b glc=%b gla=%b want 1 0 1", ghc, glc, gla);
    end
    flt = 1'b1;
    tick(1);
    flt = 1'b0;
    tick(3);
    total++;
    if ({gha, gla, ghb, glb, ghc, glc} !== 6'b0 || fault !== 1'b1) begin
      bad++;
      $display("FAIL fault_trip: gates=%b fault=%b want 000000 1", {gha, gla, ghb, glb, ghc, glc}, fault);
    end
    // CLR while FLT is still asserted must not clear the latch.
    flt = 1'b1;
    tick(3);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    total++;
    if (fault !== 1'b1) begin
      bad++;
      $display("FAIL clr_ignored: fault=%b want 1", fault);
    end
    flt = 1'b0;
    tick(6);
    total++;
    if (fault !== 1'b1 || ghc !== 1'b0) begin
      bad++;
      $display("FAIL fault_sticky: fault=%b ghc=%b want 1 0", fault, ghc);
    end
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    total++;
    if (fault !== 1'b0) begin
      bad++;
      $display("FAIL fault_clear: fault=%b want 0", fault);
    end
    for (int e = 1; e <= 6; e++) begin
      tick(1);
      total++;
      if (ghc !== (e >= 5) || gla !== (e >= 5)) begin
        bad++;
        $display("FAIL fault_reentry edge%0d: ghc=%b gla=%b want %b", e, ghc, gla, (e >= 5));
      end
    end
  endtask

  task automatic test_enable();
    en = 1'b0;
    tick(1);
    total++;
    if ({gha, gla, ghb, glb, ghc, glc} !== 6'b0) begin
      bad++;
      $display("FAIL enable_off: gates=%b want 000000", {gha, gla, ghb, glb, ghc, glc});
    end
    en = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick(1);
      total++;
      if (ghc !== (e >= 5) || gla !== (e >= 5)) begin
        bad++;
        $display("FAIL enable_on edge%0d: ghc=%b gla=%b want %b", e, ghc, gla, (e >= 5));
      end
    end
  endtask

  task automatic test_midreset();
    pha = 1'b1; pla = 1'b0;
    tick(4);
    rst_n = 1'b0;
    #1;
    total++;
    if ({gha, gla, ghb, glb, ghc, glc, fault, err} !== 10'b0) begin
      bad++;
      $display("FAIL midreset_async: got %b want 0", {gha, gla, ghb, glb, ghc, glc, fault, err});
    end
    tick(2);
    rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick(1);
      total++;
      if (gha !== (e >= 6) || gla !== 1'b0 || ghc !== (e >= 6)) begin
        bad++;
        $display("FAIL midreset_restart edge%0d: gha=%b gla=%b ghc=%b want %b 0 %b", e, gha, gla, ghc, (e >= 6), (e >= 6));
      end
    end
  endtask

  initial begin
    test_reset();
    test_handover();
    test_glitch();
    test_illegal();
    test_fault();
    test_enable();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
